// File: rtl/pc_seq_pkg.sv
// Shared definitions for the pc_sequencer control-flow block.
// Contents:
//   OP_NONE..OP_HALT : 3-bit control op encodings (6 and 7 behave as OP_NONE)
//   state_t          : sequencer FSM states (boot, free-run, halted)
package pc_seq_pkg;

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_BR   = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_HALT = 3'd5;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack: a depth-parameterised LIFO with no wrap-around.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (empties the stack)
//   push     : store din on top (ignored when full)
//   pop      : discard the top entry (ignored when empty)
//   din      : entry to push
//   dout     : current top-of-stack entry (undefined content when empty)
//   full     : DEPTH entries held
//   empty    : no entries held
// The parent detects overflow/underflow from full/empty and reports it.
module ras #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    top_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign top_ptr = cnt - CW'(1);
   assign dout    = mem[top_ptr[AW-1:0]];

   // Only the occupancy count is reset; entry contents are don't-care until written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (do_push) begin
         cnt <= cnt + CW'(1);
      end else if (do_pop) begin
         cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[cnt[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Control-flow sequencer for an external self-incrementing program counter.
// Each cycle it either lets the counter free-run (pc_we=0) or redirects it
// (pc_we=1, pc_data=new address): boot vector, stall hold, jump, branch,
// call/return through an internal return-address stack, interrupt entry, halt.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   pc              : current counter value
//   pc_we, pc_data  : combinational load strobe/value to the counter
//   stall           : hold the counter this cycle
//   op, cond, target: control op, branch condition, destination address
//   irq             : level interrupt request
//   irq_ack         : one-cycle pulse in the cycle after interrupt entry
//   halted          : high while in the halt state
//   ras_err         : sticky return-stack overflow/underflow flag
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter int               RAS_DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000,
   parameter logic [WIDTH-1:0] IRQ_VECTOR   = 16'h0008
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc,
   output logic             pc_we,
   output logic [WIDTH-1:0] pc_data,
   input  logic             stall,
   input  logic [2:0]       op,
   input  logic             cond,
   input  logic [WIDTH-1:0] target,
   input  logic             irq,
   output logic             irq_ack,
   output logic             halted,
   output logic             ras_err
);

   state_t         state_q;
   state_t         state_d;
   logic           irq_mask;
   logic           mask_d;
   logic           ack_d;
   logic           err_d;
   logic           we_d;

   logic           ras_push;
   logic           ras_pop;
   logic [WIDTH:0] ras_din;
   logic [WIDTH:0] ras_top;
   logic           ras_full;
   logic           ras_empty;

   logic [WIDTH-1:0] pc_inc;

   assign pc_inc = pc + WIDTH'(1);

   ras #(
      .WIDTH (WIDTH + 1),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (ras_din),
      .dout  (ras_top),
      .full  (ras_full),
      .empty (ras_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_BOOT;
         irq_mask <= 1'b0;
         irq_ack  <= 1'b0;
         halted   <= 1'b0;
         ras_err  <= 1'b0;
      end else begin
         state_q  <= state_d;
         irq_mask <= mask_d;
         irq_ack  <= ack_d;
         halted   <= (state_d == ST_HALT);
         ras_err  <= err_d;
      end
   end

   // Entry bit WIDTH flags an interrupt frame: only popping such a frame
   // unmasks interrupts, so CALL/RET nested inside an ISR keep the mask.
   always_comb begin
      state_d  = state_q;
      mask_d   = irq_mask;
      ack_d    = 1'b0;
      err_d    = ras_err;
      we_d     = 1'b0;
      pc_data  = pc;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      ras_din  = {1'b0, pc_inc};

      unique case (state_q)
         ST_BOOT: begin
            we_d    = 1'b1;
            pc_data = RESET_VECTOR;
            state_d = ST_RUN;
         end

         ST_RUN: begin
            if (stall) begin
               we_d    = 1'b1;
               pc_data = pc;
            end else if (irq && !irq_mask) begin
               ras_push = 1'b1;
               ras_din  = {1'b1, pc};
               we_d     = 1'b1;
               pc_data  = IRQ_VECTOR;
               mask_d   = 1'b1;
               ack_d    = 1'b1;
               if (ras_full) err_d = 1'b1;
            end else begin
               case (op)
                  OP_JMP: begin
                     we_d    = 1'b1;
                     pc_data = target;
                  end
                  OP_BR: begin
                     we_d    = cond;
                     pc_data = target;
                  end
                  OP_CALL: begin
                     ras_push = 1'b1;
                     ras_din  = {1'b0, pc_inc};
                     we_d     = 1'b1;
                     pc_data  = target;
                     if (ras_full) err_d = 1'b1;
                  end
                  OP_RET: begin
                     ras_pop = 1'b1;
                     we_d    = 1'b1;
                     if (ras_empty) begin
                        pc_data = RESET_VECTOR;
                        err_d   = 1'b1;
                     end else begin
                        pc_data = ras_top[WIDTH-1:0];
                        if (ras_top[WIDTH]) mask_d = 1'b0;
                     end
                  end
                  OP_HALT: begin
                     we_d    = 1'b1;
                     pc_data = pc;
                     state_d = ST_HALT;
                  end
                  default: begin
                     we_d = 1'b0;
                  end
               endcase
            end
         end

         ST_HALT: begin
            we_d    = 1'b1;
            pc_data = pc;
            // Return lands on the instruction after the HALT.
            if (irq && !irq_mask) begin
               ras_push = 1'b1;
               ras_din  = {1'b1, pc_inc};
               pc_data  = IRQ_VECTOR;
               mask_d   = 1'b1;
               ack_d    = 1'b1;
               state_d  = ST_RUN;
               if (ras_full) err_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase

      // The state register already sits in BOOT during reset; suppress its load.
      pc_we = we_d && !rst;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] count = 16'h5A5A;
   logic         pc_we;
   logic [W-1:0] pc_data;
   logic         stall = 1'b0;
   logic [2:0]   op = OP_NONE;
   logic         cond = 1'b0;
   logic [W-1:0] target = '0;
   logic         irq = 1'b0;
   logic         irq_ack;
   logic         halted;
   logic         ras_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Program counter model: loads when strobed, otherwise increments.
   always @(posedge clk) begin
      if (pc_we) count <= pc_data;
      else       count <= count + 16'd1;
   end

   pc_sequencer #(
      .WIDTH        (16),
      .RAS_DEPTH    (4),
      .RESET_VECTOR (16'h0000),
      .IRQ_VECTOR   (16'h0008)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pc      (count),
      .pc_we   (pc_we),
      .pc_data (pc_data),
      .stall   (stall),
      .op      (op),
      .cond    (cond),
      .target  (target),
      .irq     (irq),
      .irq_ack (irq_ack),
      .halted  (halted),
      .ras_err (ras_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [2:0] o, input logic [W-1:0] t);
      op     = o;
      target = t;
      tick();
      op     = OP_NONE;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      #2 rst = 1'b1;
      #1;
      check("rst_pc_we",   32'(pc_we),   32'h0);
      check("rst_irq_ack", 32'(irq_ack), 32'h0);
      check("rst_halted",  32'(halted),  32'h0);
      check("rst_ras_err", 32'(ras_err), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      // Boot cycle
      check("boot_we",   32'(pc_we),   32'h1);
      check("boot_data", 32'(pc_data), 32'h0000);
      tick();
      check("boot_pc0", 32'(count), 32'h0000);
      tick();
      check("boot_pc1", 32'(count), 32'h0001);
      tick();
      check("boot_pc2", 32'(count), 32'h0002);
      tick();
      check("boot_pc3", 32'(count), 32'h0003);

      // Jump / branch
      do_op(OP_JMP, 16'hDEAD);
      check("jmp", 32'(count), 32'hDEAD);
      cond = 1'b0;
      do_op(OP_BR, 16'h0100);
      check("br_not_taken", 32'(count), 32'hDEAE);
      cond = 1'b1;
      do_op(OP_BR, 16'h0100);
      check("br_taken", 32'(count), 32'h0100);
      cond = 1'b0;

      // Call / return
      do_op(OP_JMP, 16'h0010);
      do_op(OP_CALL, 16'h0200);
      check("call", 32'(count), 32'h0200);
      tick();
      tick();
      check("call_count", 32'(count), 32'h0202);
      do_op(OP_RET, 16'h0000);
      check("ret", 32'(count), 32'h0011);

      // Five calls into a four-deep stack
      do_op(OP_CALL, 16'h0100);
      do_op(OP_CALL, 16'h0200);
      do_op(OP_CALL, 16'h0300);
      do_op(OP_CALL, 16'h0400);
      check("ras_full_no_err", 32'(ras_err), 32'h0);
      do_op(OP_CALL, 16'h0500);
      check("overflow_redirect", 32'(count), 32'h0500);
      check("overflow_err", 32'(ras_err), 32'h1);
      do_op(OP_RET, 16'h0000);
      check("ret4", 32'(count), 32'h0301);
      do_op(OP_RET, 16'h0000);
      check("ret3", 32'(count), 32'h0201);
      do_op(OP_RET, 16'h0000);
      check("ret2", 32'(count), 32'h0101);
      do_op(OP_RET, 16'h0000);
      check("ret1", 32'(count), 32'h0012);
      do_op(OP_RET, 16'h0000);
      check("underflow_pc", 32'(count), 32'h0000);
      check("err_sticky", 32'(ras_err), 32'h1);

      // Interrupt entry, masking, nested call, ISR return
      do_op(OP_JMP, 16'h0020);
      irq = 1'b1;
      op  = OP_JMP;
      target = 16'h7777;
      #1;
      check("irq_we",   32'(pc_we),   32'h1);
      check("irq_data", 32'(pc_data), 32'h0008);
      tick();
      op = OP_NONE;
      check("irq_vector", 32'(count), 32'h0008);
      check("irq_ack_hi", 32'(irq_ack), 32'h1);
      tick();
      check("irq_masked", 32'(count), 32'h0009);
      check("irq_ack_lo", 32'(irq_ack), 32'h0);
      irq = 1'b0;
      do_op(OP_CALL, 16'h0300);
      check("isr_call", 32'(count), 32'h0300);
      do_op(OP_RET, 16'h0000);
      check("isr_nested_ret", 32'(count), 32'h000A);
      irq = 1'b1;
      tick();
      check("mask_kept", 32'(count), 32'h000B);
      irq = 1'b0;
      do_op(OP_RET, 16'h0000);
      check("isr_ret", 32'(count), 32'h0020);
      irq = 1'b1;
      #1;
      check("unmasked_data", 32'(pc_data), 32'h0008);
      irq = 1'b0;
      #1;

      // Stall
      do_op(OP_JMP, 16'h0030);
      stall = 1'b1;
      op = OP_JMP;
      target = 16'h4444;
      irq = 1'b1;
      tick();
      check("stall1", 32'(count), 32'h0030);
      tick();
      check("stall2", 32'(count), 32'h0030);
      irq = 1'b0;
      op = OP_NONE;
      tick();
      check("stall3", 32'(count), 32'h0030);
      stall = 1'b0;
      tick();
      check("stall_resume", 32'(count), 32'h0031);

      // Halt and wake by interrupt
      do_op(OP_JMP, 16'h0040);
      do_op(OP_HALT, 16'h0000);
      check("halt_pc", 32'(count), 32'h0040);
      check("halted_hi", 32'(halted), 32'h1);
      stall = 1'b1;
      do_op(OP_JMP, 16'h1234);
      stall = 1'b0;
      tick();
      check("halt_frozen", 32'(count), 32'h0040);
      irq = 1'b1;
      tick();
      irq = 1'b0;
      check("halt_wake", 32'(count), 32'h0008);
      check("halt_wake_ack", 32'(irq_ack), 32'h1);
      check("halted_lo", 32'(halted), 32'h0);
      do_op(OP_RET, 16'h0000);
      check("halt_ret", 32'(count), 32'h0041);

      // Wrap of the return address
      do_op(OP_JMP, 16'hFFFF);
      do_op(OP_CALL, 16'h0050);
      check("wrap_call", 32'(count), 32'h0050);
      do_op(OP_RET, 16'h0000);
      check("wrap_ret", 32'(count), 32'h0000);

      // Reset in the middle of an ISR
      do_op(OP_JMP, 16'h0060);
      do_op(OP_CALL, 16'h0070);
      irq = 1'b1;
      tick();
      irq = 1'b0;
      check("pre_rst_ack", 32'(irq_ack), 32'h1);
      check("pre_rst_err", 32'(ras_err), 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_ack", 32'(irq_ack), 32'h0);
      check("mid_rst_err", 32'(ras_err), 32'h0);
      check("mid_rst_we",  32'(pc_we),   32'h0);
      tick();
      rst = 1'b0;
      tick();
      check("reboot_pc", 32'(count), 32'h0000);
      check("reboot_halted", 32'(halted), 32'h0);
      tick();
      check("reboot_pc1", 32'(count), 32'h0001);
      do_op(OP_RET, 16'h0000);
      check("reboot_ras_empty", 32'(count), 32'h0000);
      check("reboot_underflow_err", 32'(ras_err), 32'h1);
      irq = 1'b1;
      tick();
      irq = 1'b0;
      check("reboot_mask_clear", 32'(count), 32'h0008);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control-flow sequencer for the `pc` program counter. The counter self-increments every clock and loads `data` when `we` is high. `pc_sequencer` decides each cycle whether the counter free-runs or is redirected: boot vector, stall hold, jump, conditional branch, call/return through an internal return-address stack (RAS), interrupt entry or halt. It sits between the decoder/interrupt logic and `pc`, drives `pc.we`/`pc.data`, and reads back `pc.count`.

## Interface
- `WIDTH`, 16, address width (matches `pc`)
- `RAS_DEPTH`, 4, return-address stack entries (power of 2, ≥2)
- `RESET_VECTOR`, 16'h0000, boot address and RET-underflow target
- `IRQ_VECTOR`, 16'h0008, interrupt entry address
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pc`  in  WIDTH  current `pc.count`
- `pc_we`  out  1  load strobe to `pc.we` (combinational)
- `pc_data`  out  WIDTH  load value to `pc.data` (combinational)
- `stall`  in  1  hold PC this cycle
- `op`  in  3  control op: NONE=0, JMP=1, BR=2, CALL=3, RET=4, HALT=5; 6–7 treated as NONE
- `cond`  in  1  branch condition, used only for BR
- `target`  in  WIDTH  jump/branch/call destination
- `irq`  in  1  interrupt request, level
- `irq_ack`  out  1  registered 1-cycle pulse, cycle after interrupt entry
- `halted`  out  1  registered, high in HALT state
- `ras_err`  out  1  registered sticky RAS overflow/underflow flag

## Operation
- States: BOOT, RUN, HALT. `rst` → BOOT, RAS empty, `irq_mask`=0, `irq_ack`=0, `halted`=0, `ras_err`=0.
- BOOT (one cycle): `pc_we`=1, `pc_data`=RESET_VECTOR; → RUN. Inputs ignored.
- RUN, priority stall > irq > op:
  - `stall`: `pc_we`=1, `pc_data`=`pc` (hold). No RAS change, `irq` not taken.
  - `irq` && !`irq_mask`: push {flag=1, `pc`}; load IRQ_VECTOR; set `irq_mask`; `op` this cycle discarded.
  - JMP: load `target`. BR: load `target` if `cond`, else `pc_we`=0.
  - CALL: push {flag=0, `pc`+1}; load `target`.
  - RET: pop entry; load its address; if its flag=1, clear `irq_mask`.
  - HALT: `pc_we`=1, `pc_data`=`pc`; → HALT.
  - NONE: `pc_we`=0 (counter increments).
- HALT: hold `pc` every cycle (`pc_we`=1, `pc_data`=`pc`). Leave only via unmasked `irq`: push {1,`pc`+1}, load IRQ_VECTOR, → RUN. `stall` and `op` ignored.
- Arithmetic: `pc`+1 is modulo 2^WIDTH (FFFF+1 = 0000).
- RAS boundaries: push when full → push dropped, redirect still taken, `ras_err` set. Pop when empty → `pc_data`=RESET_VECTOR, `irq_mask` unchanged, `ras_err` set. `ras_err` is cleared only by `rst`.
- Flag bit per entry: nested CALLs inside an ISR do not unmask on their RET; only the ISR's own RET unmasks.

## Timing
- Redirects take effect at the next rising edge: the cycle after `pc_we`=1, `pc.count` equals `pc_data`.
- `pc_we`/`pc_data` are combinational from state, `pc` and inputs. Upstream must hold inputs stable before the edge.
- RAS push/pop, `irq_mask`, state, `irq_ack`, `halted` and `ras_err` update on the same edge as the PC load.
- `irq_ack` is high exactly one cycle, the cycle after entry.
- `rst` asserted mid-operation immediately zeroes all registered outputs and empties the RAS. `pc_we` is 0 while `rst` is high. BOOT occurs on the first edge after release.

## Structure
- Package `pc_seq_pkg`: op encodings (OP_NONE…OP_HALT), state enum (ST_BOOT, ST_RUN, ST_HALT).
- Sub-module `ras`: depth-parameterised LIFO of WIDTH+1 bits with push/pop, `full`, `empty`, top-of-stack output, async reset. Overflow/underflow are reported to the parent; no wrap.
- Top level: FSM, priority mux and `irq_mask`. `pc` is instantiated only in the bench.

## Test plan
- Boot: pulse `rst`, release → one cycle `pc_we`=1/`pc_data`=0000, then count 0000,0001,0002…
- Jump/branch: at pc 0003 JMP `target`=DEAD → next DEAD. BR `cond`=0 → DEAE. BR `cond`=1 `target`=0100 → 0100.
- Call/return: at 0010 CALL 0200, count to 0202, RET → 0011. Five CALLs with RAS_DEPTH=4 → `ras_err`=1. Four RETs return correctly, fifth RET → 0000.
- Interrupt: at 0020 assert `irq` → 0008, `irq_ack` one cycle later. Second `irq` masked. Nested CALL/RET in ISR keeps mask. ISR RET → 0020, mask cleared.
- Stall/halt: `stall` 3 cycles at 0030 → pc stays 0030, resumes 0031. HALT at 0040 → `halted`=1, pc frozen. `irq` → 0008, return via RET to 0041.
- Wrap and reset: CALL at FFFF pushes 0000. `rst` asserted mid-ISR → RAS empty, `ras_err`/`halted`/`irq_ack` 0, reboot to 0000.
